pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter MUL_CYCLES, default 4, total EX-stage cycles of a multiply (legal range 2..15).
REQ-003 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rt  input  REG_W each  ID source specifiers.
REQ-007 SHALL have port id_uses_rt  input  1  ID instruction reads rt.
REQ-008 SHALL have port id_is_mul  input  1  ID instruction is a multi-cycle multiply.
REQ-009 SHALL have ports ex_mem_read  input  1 and ex_rt  input  REG_W  load in EX and its destination.
REQ-010 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-011 SHALL have outputs pc_en, ifid_en, idex_en  1 each  stage-register enables (EN of each stage).
REQ-012 SHALL have outputs ifid_clr, idex_clr, exmem_clr  1 each  stage-register clears (CLR of each stage).
REQ-013 SHALL have output mul_busy  1  multiply stall in progress.
REQ-014 SHALL have output stall_cnt  16  count of cycles with pc_en=0 since reset.

Function
REQ-015 SHALL implement FSM states RUN and MUL; a REG_W-independent 4-bit down-counter mul_ctr.
REQ-016 SHALL drive enable/clear outputs combinationally from state and current inputs (same-cycle response).
REQ-017 In RUN with no event: pc_en=ifid_en=idex_en=1, all clears=0.
REQ-018 Load-use hazard SHALL be: id_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-019 In RUN on hazard (no branch): pc_en=0, ifid_en=0, idex_clr=1, idex_en=1; exactly one bubble per hazard cycle.
REQ-020 In RUN on ex_branch_taken: pc_en=1, ifid_clr=1, idex_clr=1; branch SHALL override hazard and multiply start in the same cycle.
REQ-021 In RUN, id_valid & id_is_mul & no hazard & no branch: normal advance this cycle; next state MUL, mul_ctr<=MUL_CYCLES-1.
REQ-022 In MUL: pc_en=0, ifid_en=0, idex_en=0, exmem_clr=1, mul_busy=1; mul_ctr decrements each cycle.
REQ-023 In MUL, when mul_ctr==1: next state RUN; mul stays in EX for exactly MUL_CYCLES cycles total.
REQ-024 In MUL, ex_branch_taken, ex_mem_read and all ID inputs SHALL be ignored.
REQ-025 mul_busy SHALL be 0 in RUN.
REQ-026 stall_cnt SHALL increment on each rising edge where pc_en=0 and RST=0; saturate at 16'hFFFF (no wrap).
REQ-027 ex_rt==0 SHALL never cause a stall (register 0 hardwired).

Reset
REQ-028 RST=1 SHALL immediately force state=RUN, mul_ctr=0, stall_cnt=0, regardless of CLK.
REQ-029 While RST=1: pc_en=ifid_en=idex_en=0, ifid_clr=idex_clr=exmem_clr=1, mul_busy=0.
REQ-030 RST asserted mid-MUL SHALL abort the multiply; first cycle after release is RUN with REQ-017 outputs.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_valid=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle; stall_cnt 0->1.
REQ-032 Zero reg: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, pc_en=1, stall_cnt unchanged.
REQ-033 Multiply (MUL_CYCLES=4): id_is_mul=1 one cycle -> mul_busy=1 for next 3 cycles, pc_en=0, exmem_clr=1; RUN on 4th; stall_cnt=3.
REQ-034 Branch+hazard same cycle: ex_branch_taken=1 with load-use true -> pc_en=1, ifid_clr=1, idex_clr=1, no stall.
REQ-035 Reset mid-MUL: assert RST during 2nd MUL cycle off-edge -> outputs per REQ-029 immediately, stall_cnt=0; after release RUN, mul_busy=0.
REQ-036 Saturation: preload via 65535+ stall cycles -> stall_cnt holds 16'hFFFF, no wrap to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// multi-cycle multiply freeze, with a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_mul,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             mul_busy,
  output logic [15:0]      stall_cnt
);

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MUL = 1'b1;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  mul_ctr_q, mul_ctr_d;
  logic [15:0] stall_q, stall_d;

  logic hazard;
  logic mul_start;

  // register 0 is hardwired, so a load targeting it never stalls
  assign hazard = id_valid & ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign mul_start = (state_q == RUN) & id_valid & id_is_mul &
                     ~hazard & ~ex_branch_taken;

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    mul_busy  = 1'b0;
    if (RST) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (state_q == MUL) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_clr = 1'b1;
      mul_busy  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (hazard) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_ctr_d = mul_ctr_q;
    if (state_q == MUL) begin
      if (mul_ctr_q == 4'd1) begin
        state_d   = RUN;
        mul_ctr_d = 4'd0;
      end else begin
        mul_ctr_d = mul_ctr_q - 4'd1;
      end
    end else if (mul_start) begin
      state_d   = MUL;
      mul_ctr_d = MUL_LOAD;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      mul_ctr_q <= 4'd0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      mul_ctr_q <= mul_ctr_d;
      stall_q   <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule
